// File: rtl/rs_ooo_station_pkg.sv
// Shared configuration defaults for the ALU reservation station and the
// selection logic it shares with the load/store buffer.
package rs_ooo_station_pkg;

  localparam int CFG_RS_SIZE_BIT   = 3;
  localparam int CFG_RS_TYPE_BIT   = 4;
  localparam int CFG_ROB_WIDTH_BIT = 6;
  localparam int CFG_RS_N_CDB      = 2;
  localparam int DATA_W            = 32;

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational oldest-ready picker: grants the ready entry that no other
// ready entry is older than, using an insertion-order age matrix.
module rs_oldest_select
  import rs_ooo_station_pkg::*;
#(
  parameter int SIZE_BIT = CFG_RS_SIZE_BIT
) (
  input  logic [(1<<SIZE_BIT)-1:0]                      ready,
  input  logic [(1<<SIZE_BIT)-1:0][(1<<SIZE_BIT)-1:0]   older,
  output logic [(1<<SIZE_BIT)-1:0]                      grant,
  output logic [SIZE_BIT-1:0]                           grant_idx
);

  localparam int SIZE = 1 << SIZE_BIT;

  logic [SIZE-1:0] blocked;

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path can leave it unassigned and infer a latch.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  assign grant = ready & ~blocked;

  always_comb begin
    grant_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (grant[i]) grant_idx = i[SIZE_BIT-1:0];
    end
  end

endmodule

// File: rtl/rs_ooo_station.sv
// Out-of-order reservation station for the scalar ALU: holds renamed
// instructions, snoops result buses for operands, issues the oldest ready one.
module rs_ooo_station
  import rs_ooo_station_pkg::*;
#(
  parameter int RS_SIZE_BIT = CFG_RS_SIZE_BIT,
  parameter int N_CDB       = CFG_RS_N_CDB,
  parameter int TYPE_BIT    = CFG_RS_TYPE_BIT,
  parameter int ROB_W       = CFG_ROB_WIDTH_BIT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic                      inst_valid,
  input  logic [TYPE_BIT-1:0]       inst_type,
  input  logic [ROB_W-1:0]          inst_rob_id,
  input  logic [31:0]               inst_r1,
  input  logic [31:0]               inst_r2,
  input  logic                      inst_has_dep1,
  input  logic                      inst_has_dep2,
  input  logic [ROB_W-1:0]          inst_dep1,
  input  logic [ROB_W-1:0]          inst_dep2,
  output logic                      full,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]    cdb_rob_id,
  input  logic [N_CDB*32-1:0]       cdb_value,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [TYPE_BIT-1:0]       issue_type,
  output logic [ROB_W-1:0]          issue_rob_id,
  output logic [31:0]               issue_r1,
  output logic [31:0]               issue_r2
);

  localparam int RS_SIZE = 1 << RS_SIZE_BIT;
  localparam int CW      = RS_SIZE_BIT + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RS_SIZE);

  logic [RS_SIZE-1:0]               busy, has_dep1, has_dep2;
  logic [TYPE_BIT-1:0]              e_type [RS_SIZE];
  logic [ROB_W-1:0]                 e_rob  [RS_SIZE];
  logic [ROB_W-1:0]                 e_dep1 [RS_SIZE];
  logic [ROB_W-1:0]                 e_dep2 [RS_SIZE];
  logic [DATA_W-1:0]                e_r1   [RS_SIZE];
  logic [DATA_W-1:0]                e_r2   [RS_SIZE];
  logic [RS_SIZE-1:0][RS_SIZE-1:0]  older;
  logic [CW-1:0]                    count, count_next;

  // Returns {hit, value}; scanning from the top down lets bus 0 win ties.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [ROB_W-1:0]       tag,
    input logic [N_CDB-1:0]       cv,
    input logic [N_CDB*ROB_W-1:0] ids,
    input logic [N_CDB*32-1:0]    vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (cv[k] && ids[k*ROB_W +: ROB_W] == tag) res = {1'b1, vals[k*32 +: 32]};
    end
    return res;
  endfunction

  logic                    has_free;
  logic [RS_SIZE_BIT-1:0]  free_idx;

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        has_free = 1'b1;
        free_idx = i[RS_SIZE_BIT-1:0];
      end
    end
  end

  logic [DATA_W:0] ins_m1, ins_m2;
  logic            ins_hit1, ins_hit2;

  assign ins_m1   = cdb_match(inst_dep1, cdb_valid, cdb_rob_id, cdb_value);
  assign ins_m2   = cdb_match(inst_dep2, cdb_valid, cdb_rob_id, cdb_value);
  assign ins_hit1 = inst_has_dep1 && ins_m1[DATA_W];
  assign ins_hit2 = inst_has_dep2 && ins_m2[DATA_W];

  logic [RS_SIZE-1:0] wk_hit1, wk_hit2;
  logic [DATA_W-1:0]  wk_val1 [RS_SIZE];
  logic [DATA_W-1:0]  wk_val2 [RS_SIZE];

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      logic [DATA_W:0] m1, m2;
      m1 = cdb_match(e_dep1[i], cdb_valid, cdb_rob_id, cdb_value);
      m2 = cdb_match(e_dep2[i], cdb_valid, cdb_rob_id, cdb_value);
      wk_hit1[i] = busy[i] && has_dep1[i] && m1[DATA_W];
      wk_hit2[i] = busy[i] && has_dep2[i] && m2[DATA_W];
      wk_val1[i] = m1[DATA_W-1:0];
      wk_val2[i] = m2[DATA_W-1:0];
    end
  end

  logic [RS_SIZE-1:0]     ready, grant;
  logic [RS_SIZE_BIT-1:0] sel_idx;

  assign ready = busy & ~has_dep1 & ~has_dep2;

  rs_oldest_select #(.SIZE_BIT(RS_SIZE_BIT)) u_select (
    .ready     (ready),
    .older     (older),
    .grant     (grant),
    .grant_idx (sel_idx)
  );

  // Issue data comes straight from registered entries; a CDB hit this cycle
  // only becomes visible after the edge.
  assign issue_valid  = |ready;
  assign issue_type   = e_type[sel_idx];
  assign issue_rob_id = e_rob[sel_idx];
  assign issue_r1     = e_r1[sel_idx];
  assign issue_r2     = e_r2[sel_idx];

  logic do_insert, do_xfer;

  assign do_insert  = inst_valid && rdy_in && !flush && has_free;
  assign do_xfer    = issue_valid && issue_ready && rdy_in && !flush;
  assign count_next = count + {{RS_SIZE_BIT{1'b0}}, do_insert}
                            - {{RS_SIZE_BIT{1'b0}}, do_xfer};

  // NOTE: state registers use non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy     <= '0;
      has_dep1 <= '0;
      has_dep2 <= '0;
      older    <= '0;
      count    <= '0;
      full     <= 1'b0;
      // NOTE: payload storage is cleared too, because issue_* must read as
      // zero straight out of reset rather than whatever the array held.
      for (int i = 0; i < RS_SIZE; i++) begin
        e_type[i] <= '0;
        e_rob[i]  <= '0;
        e_dep1[i] <= '0;
        e_dep2[i] <= '0;
        e_r1[i]   <= '0;
        e_r2[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        busy  <= '0;
        older <= '0;
        count <= '0;
        full  <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (wk_hit1[i]) begin
            e_r1[i]     <= wk_val1[i];
            has_dep1[i] <= 1'b0;
          end
          if (wk_hit2[i]) begin
            e_r2[i]     <= wk_val2[i];
            has_dep2[i] <= 1'b0;
          end
          if (do_xfer && grant[i]) busy[i] <= 1'b0;
        end
        if (do_insert) begin
          busy[free_idx]     <= 1'b1;
          e_type[free_idx]   <= inst_type;
          e_rob[free_idx]    <= inst_rob_id;
          e_dep1[free_idx]   <= inst_dep1;
          e_dep2[free_idx]   <= inst_dep2;
          e_r1[free_idx]     <= ins_hit1 ? ins_m1[DATA_W-1:0] : inst_r1;
          e_r2[free_idx]     <= ins_hit2 ? ins_m2[DATA_W-1:0] : inst_r2;
          has_dep1[free_idx] <= inst_has_dep1 && !ins_hit1;
          has_dep2[free_idx] <= inst_has_dep2 && !ins_hit2;
          // New entry is younger than everything resident, older than nothing.
          for (int x = 0; x < RS_SIZE; x++) begin
            older[x][free_idx] <= busy[x];
            older[free_idx][x] <= 1'b0;
          end
        end
        count <= count_next;
        full  <= (count_next == FULL_CNT);
      end
    end
  end

endmodule

// File: tb/tb_rs_ooo_station.sv
// Directed-vector bench for rs_ooo_station: expected issues are queued at
// stimulus time and a negedge monitor checks each accepted transfer.
module tb_rs_ooo_station;
  import rs_ooo_station_pkg::*;

  localparam int SB = 3;
  localparam int NC = 2;
  localparam int TW = 4;
  localparam int RW = 6;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, flush;
  logic              inst_valid;
  logic [TW-1:0]     inst_type;
  logic [RW-1:0]     inst_rob_id, inst_dep1, inst_dep2;
  logic [31:0]       inst_r1, inst_r2;
  logic              inst_has_dep1, inst_has_dep2;
  logic              full;
  logic [NC-1:0]     cdb_valid;
  logic [NC*RW-1:0]  cdb_rob_id;
  logic [NC*32-1:0]  cdb_value;
  logic              issue_valid, issue_ready;
  logic [TW-1:0]     issue_type;
  logic [RW-1:0]     issue_rob_id;
  logic [31:0]       issue_r1, issue_r2;

  rs_ooo_station #(.RS_SIZE_BIT(SB), .N_CDB(NC), .TYPE_BIT(TW), .ROB_W(RW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .flush         (flush),
    .inst_valid    (inst_valid),
    .inst_type     (inst_type),
    .inst_rob_id   (inst_rob_id),
    .inst_r1       (inst_r1),
    .inst_r2       (inst_r2),
    .inst_has_dep1 (inst_has_dep1),
    .inst_has_dep2 (inst_has_dep2),
    .inst_dep1     (inst_dep1),
    .inst_dep2     (inst_dep2),
    .full          (full),
    .cdb_valid     (cdb_valid),
    .cdb_rob_id    (cdb_rob_id),
    .cdb_value     (cdb_value),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_type    (issue_type),
    .issue_rob_id  (issue_rob_id),
    .issue_r1      (issue_r1),
    .issue_r2      (issue_r2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [RW-1:0] rob;
    logic [TW-1:0] typ;
    logic [31:0]   r1;
    logic [31:0]   r2;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [RW-1:0] tag, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.rob = tag;
    e.typ = tag[TW-1:0];
    e.r1  = r1;
    e.r2  = r2;
    sb_q.push_back(e);
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (!rst_in && rdy_in && !flush && issue_valid && issue_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_issue: got rob %0d expected none", issue_rob_id);
      end else begin
        e = sb_q.pop_front();
        check("issue_rob", 32'(issue_rob_id), 32'(e.rob));
        check("issue_type", 32'(issue_type), 32'(e.typ));
        check("issue_r1", issue_r1, e.r1);
        check("issue_r2", issue_r2, e.r2);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_inst(input logic [RW-1:0] tag, input logic [31:0] r1, input logic [31:0] r2,
                            input logic hd1, input logic [RW-1:0] d1,
                            input logic hd2, input logic [RW-1:0] d2);
    inst_valid    = 1'b1;
    inst_rob_id   = tag;
    inst_type     = tag[TW-1:0];
    inst_r1       = r1;
    inst_r2       = r2;
    inst_has_dep1 = hd1;
    inst_dep1     = d1;
    inst_has_dep2 = hd2;
    inst_dep2     = d2;
  endtask

  task automatic insert(input logic [RW-1:0] tag, input logic [31:0] r1, input logic [31:0] r2,
                        input logic hd1, input logic [RW-1:0] d1,
                        input logic hd2, input logic [RW-1:0] d2);
    drive_inst(tag, r1, r2, hd1, d1, hd2, d2);
    tick();
    inst_valid = 1'b0;
  endtask

  task automatic set_cdb(input int k, input logic [RW-1:0] tag, input logic [31:0] val);
    cdb_valid[k]           = 1'b1;
    cdb_rob_id[k*RW +: RW] = tag;
    cdb_value[k*32 +: 32]  = val;
  endtask

  task automatic clr_cdb();
    cdb_valid  = '0;
    cdb_rob_id = '0;
    cdb_value  = '0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    inst_valid = 1'b0; inst_type = '0; inst_rob_id = '0; inst_r1 = '0; inst_r2 = '0;
    inst_has_dep1 = 1'b0; inst_has_dep2 = 1'b0; inst_dep1 = '0; inst_dep2 = '0;
    clr_cdb();
    repeat (2) tick();
    rst_in = 1'b0;
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    check("reset_full", 32'(full), 32'd0);
    check("reset_issue_rob", 32'(issue_rob_id), 32'd0);
    check("reset_issue_r1", issue_r1, 32'd0);

    // Independent ops issue in insertion order, first one the cycle after insert.
    issue_ready = 1'b1;
    insert(6'd1, 32'h11, 32'h12, 1'b0, '0, 1'b0, '0); push(6'd1, 32'h11, 32'h12);
    check("indep_first_valid", 32'(issue_valid), 32'd1);
    check("indep_first_rob", 32'(issue_rob_id), 32'd1);
    insert(6'd2, 32'h21, 32'h22, 1'b0, '0, 1'b0, '0); push(6'd2, 32'h21, 32'h22);
    insert(6'd3, 32'h31, 32'h32, 1'b0, '0, 1'b0, '0); push(6'd3, 32'h31, 32'h32);
    drain("indep_drain");
    tick();
    check("indep_empty", 32'(issue_valid), 32'd0);

    // Wakeup: 6 issues while 5 waits; 5 is eligible only after the CDB edge.
    insert(6'd5, 32'h0, 32'h52, 1'b1, 6'd9, 1'b0, '0);
    insert(6'd6, 32'h61, 32'h62, 1'b0, '0, 1'b0, '0); push(6'd6, 32'h61, 32'h62);
    set_cdb(1, 6'd9, 32'h1234); push(6'd5, 32'h1234, 32'h52);
    tick();
    clr_cdb();
    check("wake_next_rob", 32'(issue_rob_id), 32'd5);
    drain("wake_drain");

    // Age order with both ready together; bus 0 wins when two buses match.
    issue_ready = 1'b0;
    insert(6'd10, 32'h0, 32'ha2, 1'b1, 6'd9, 1'b0, '0);
    insert(6'd11, 32'hb1, 32'hb2, 1'b0, '0, 1'b0, '0);
    set_cdb(0, 6'd9, 32'h1111); set_cdb(1, 6'd9, 32'h2222);
    tick();
    clr_cdb();
    check("age_oldest_rob", 32'(issue_rob_id), 32'd10);
    push(6'd10, 32'h1111, 32'ha2); push(6'd11, 32'hb1, 32'hb2);
    issue_ready = 1'b1;
    drain("age_drain");

    // Same-cycle bypass on dispatch.
    set_cdb(0, 6'd7, 32'hdead);
    insert(6'd4, 32'h44, 32'h0, 1'b0, '0, 1'b1, 6'd7); push(6'd4, 32'h44, 32'hdead);
    clr_cdb();
    check("bypass_valid", 32'(issue_valid), 32'd1);
    check("bypass_r2", issue_r2, 32'hdead);
    drain("bypass_drain");

    // Fill to capacity, over-insert ignored, one transfer clears full.
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      insert(6'(20 + i), 32'(i), 32'h0, 1'b0, '0, 1'b0, '0);
      check("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end
    insert(6'd28, 32'h99, 32'h0, 1'b0, '0, 1'b0, '0);
    check("overfill_full", 32'(full), 32'd1);
    push(6'd20, 32'd0, 32'h0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("after_xfer_full", 32'(full), 32'd0);
    check("after_xfer_sb", 32'(sb_q.size()), 32'd0);

    // Flush with a simultaneous insert drops everything.
    flush = 1'b1;
    drive_inst(6'd29, 32'h0, 32'h0, 1'b0, '0, 1'b0, '0);
    tick();
    flush = 1'b0; inst_valid = 1'b0;
    check("flush_issue_valid", 32'(issue_valid), 32'd0);
    check("flush_full", 32'(full), 32'd0);
    for (int i = 0; i < 8; i++) begin
      insert(6'(30 + i), 32'h0, 32'h0, 1'b0, '0, 1'b0, '0);
      check("refill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_issue_valid", 32'(issue_valid), 32'd0);

    // Stall: broadcasts, dispatch and issue_ready all ignored while rdy_in is low.
    insert(6'd40, 32'h0, 32'h402, 1'b1, 6'd12, 1'b0, '0);
    insert(6'd41, 32'h411, 32'h412, 1'b0, '0, 1'b0, '0); push(6'd41, 32'h411, 32'h412);
    rdy_in = 1'b0; issue_ready = 1'b1;
    set_cdb(0, 6'd12, 32'h5555);
    drive_inst(6'd42, 32'h421, 32'h422, 1'b0, '0, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_valid", 32'(issue_valid), 32'd1);
      check("stall_rob", 32'(issue_rob_id), 32'd41);
    end
    rdy_in = 1'b1; inst_valid = 1'b0;
    clr_cdb();
    set_cdb(0, 6'd12, 32'h6666); push(6'd40, 32'h6666, 32'h402);
    tick();
    clr_cdb();
    drain("stall_drain");
    repeat (2) tick();
    check("stall_empty", 32'(issue_valid), 32'd0);

    // Reset mid-operation dominates insert and flush.
    issue_ready = 1'b0;
    insert(6'd50, 32'h501, 32'h502, 1'b0, '0, 1'b0, '0);
    insert(6'd51, 32'h511, 32'h512, 1'b0, '0, 1'b0, '0);
    rst_in = 1'b1; flush = 1'b1;
    drive_inst(6'd52, 32'h521, 32'h522, 1'b0, '0, 1'b0, '0);
    tick();
    rst_in = 1'b0; flush = 1'b0; inst_valid = 1'b0;
    check("midrst_valid", 32'(issue_valid), 32'd0);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_rob", 32'(issue_rob_id), 32'd0);
    check("midrst_r2", issue_r2, 32'd0);
    issue_ready = 1'b1;
    repeat (2) tick();
    check("final_sb", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs_ooo_station.md
# rs_ooo_station

Parametrised out-of-order reservation station for the scalar ALU path: buffers renamed instructions, captures operands from N result broadcast buses, and issues the oldest ready entry to a downstream execution unit over a valid/ready handshake. Sits between the dispatch stage (ROB-tagged instructions in) and the ALU (operands out). It also supports a pipeline-wide flush on misprediction.

## Interface
- RS_SIZE_BIT, default `RS_SIZE_BIT, log2 entry count (RS_SIZE = 1<<RS_SIZE_BIT)
- N_CDB, default 2, number of result broadcast buses snooped
- TYPE_BIT, default `RS_TYPE_BIT, opcode/work-type width
- ROB_W, default `ROB_WIDTH_BIT, ROB tag width
- clk_in  in  1  system clock, single clock domain
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global stall; low freezes all state
- flush  in  1  clear all entries (misprediction)
- inst_valid  in  1  dispatch strobe
- inst_type  in  TYPE_BIT  work type
- inst_rob_id  in  ROB_W  destination ROB tag
- inst_r1, inst_r2  in  32  operand values when no dependency
- inst_has_dep1, inst_has_dep2  in  1  operand pending
- inst_dep1, inst_dep2  in  ROB_W  producer tags
- full  out  1  registered, no free entry after this cycle
- cdb_valid  in  N_CDB  per-bus broadcast valid
- cdb_rob_id  in  N_CDB*ROB_W  packed tags, bus k at [k*ROB_W +: ROB_W]
- cdb_value  in  N_CDB*32  packed values
- issue_valid  out  1  an entry is ready
- issue_ready  in  1  execution unit accepts
- issue_type  out  TYPE_BIT; issue_rob_id  out  ROB_W; issue_r1, issue_r2  out  32

## Operation
- Entry state: busy, type, rob_id, r1/r2, has_dep1/2, dep1/2, plus an RS_SIZE×RS_SIZE age matrix (older[i][j]=1 ⇒ i inserted before j).
- Insert: when inst_valid && rdy_in && !flush, write the lowest-index free entry. For each operand with has_dep set, match against all valid CDB buses in the same cycle; on a hit store the value and clear has_dep (bypass). If several buses match, the lowest bus index wins. On insert, set older[x][new]=1 for every busy x and clear older[new][*].
- Wakeup: every busy entry with has_depN and dep matching a valid bus captures the value and clears has_depN. Lowest bus index wins.
- Ready entry: busy && !has_dep1 && !has_dep2. Select the ready entry that no other ready entry is older than. issue_* are combinational from registered state for that entry; issue_valid = any ready entry.
- Issue transfer: issue_valid && issue_ready && rdy_in frees that entry at the clock edge.
- Count: count_next = count + insert − transfer. full <= (count_next == RS_SIZE). Inserting while full is a dispatch protocol violation; it is ignored and the count is unchanged.
- Flush (rdy_in high): clear all busy, count=0, full=0. A simultaneous insert is dropped. issue_valid still reflects pre-flush state in the flush cycle, but any transfer in that cycle is discarded.
- rdy_in low: no state change. issue_valid still driven, but no transfer occurs.

## Timing
- Reset: all busy=0, count=0, full=0, issue_valid=0, issue_* data=0 (zeroed entries), age matrix 0.
- Insert→eligible: an entry inserted with no dependencies (or bypassed) can issue the cycle after insertion.
- Wakeup→eligible: one cycle after the CDB cycle; no same-cycle CDB→issue forwarding.
- Issue→reuse: a freed entry can be re-filled in the next cycle. The issue slot and insert slot may be the same cycle, on different entries.
- full reflects the edge just taken. Dispatch that samples full=0 may insert exactly one instruction this cycle.
- Reset mid-operation dominates flush, insert and issue.

## Structure
- `RS_SIZE_BIT`, `RS_TYPE_BIT` and `ROB_WIDTH_BIT` belong in const.v; add `RS_N_CDB` there.
- Sub-module rs_oldest_select: combinational, takes ready vector + age matrix, outputs one-hot grant plus index. It is reused by the LSB.
- Free-slot search is a priority encoder, inline.

## Test plan
- Independent ops: insert 3 entries with no deps (tags 1,2,3), issue_ready=1 → issued in order 1,2,3, one per cycle starting the cycle after the first insert.
- Wakeup ordering: insert tag 5 (dep1=9), then tag 6 (ready); broadcast tag 9 value 0x1234 on bus 1 → 6 issues first, then 5 with r1=0x1234; age selects 5 over any later-ready entry.
- Same-cycle bypass: insert tag 4 with dep2=7 while bus 0 broadcasts tag 7 value 0xdead → entry is ready next cycle, issue_r2=0xdead.
- Backpressure/full: RS_SIZE=8, issue_ready=0, insert 8 → full=1 after the 8th edge, 9th insert ignored; one transfer → full=0 next cycle.
- Flush: 5 busy entries, flush with simultaneous insert → next cycle issue_valid=0, full=0, count 0.
- Stall: rdy_in=0 for 3 cycles with broadcasts and issue_ready=1 → no entry changes, no transfers; resume matches the unstalled sequence.
